// File: rtl/mem_wait_responder.sv
// mem_wait_responder: fixed-wait-state memory responder with an on-chip RAM.
// A level-held Mem_OE / Mem_WE strobe starts one access. Read data becomes valid
// in strobe cycle WAIT_STATES. A write commits at the edge that ends strobe cycle
// WAIT_STATES.
// An access starts only on the rising edge of a strobe. This means a strobe that
// is still held high after an access, a conflict or an abort never starts a
// second access.
// Optional feature macro: MEM_PROTECT_EN. When it is defined, writes below
// PROT_TOP are rejected at the commit edge.
module mem_wait_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 3,
    parameter int PROT_TOP    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Rd_Valid,
    output logic              Wr_Done,
    output logic              Busy,
    output logic              Err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_HOLD = 3'd2,
        S_WR_WAIT = 3'd3,
        S_WR_HOLD = 3'd4
    } state_t;

    // Counter values seen in the last wait cycle of a read and of a write
    localparam logic [3:0] LP_RD_LAST = 4'(WAIT_STATES - 2);
    localparam logic [3:0] LP_WR_LAST = 4'(WAIT_STATES - 1);

`ifdef MEM_PROTECT_EN
    localparam logic LP_PROT_EN = 1'b1;
`else
    localparam logic LP_PROT_EN = 1'b0;
`endif

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd_valid;
    logic              r_wr_done;
    logic              r_err;
    logic              r_busy;
    logic              r_oe_d;
    logic              r_we_d;

    state_t            w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_latch;
    logic              w_load_rd;
    logic              w_clr_valid;
    logic              w_wr_done_nxt;
    logic              w_err_nxt;
    logic              w_mem_we;
    logic              w_oe_rise;
    logic              w_we_rise;
    logic              w_prot_hit;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_oe_rise  = Mem_OE & ~r_oe_d;
    assign w_we_rise  = Mem_WE & ~r_we_d;
    assign w_prot_hit = LP_PROT_EN & (r_addr < ADDR_W'(PROT_TOP));
    // With only two wait states the RAM is read straight from IDLE, before the address is latched
    assign w_rd_addr  = (r_state == S_IDLE) ? ADDR : r_addr;

    // Next-state, counter and registered-output decisions for the access FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_cnt == 4'hF) ? r_cnt : (r_cnt + 4'd1);
        w_latch       = 1'b0;
        w_load_rd     = 1'b0;
        w_clr_valid   = 1'b0;
        w_wr_done_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_mem_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (Mem_OE && Mem_WE) begin
                    w_err_nxt = w_oe_rise | w_we_rise;
                end else if (w_oe_rise) begin
                    w_latch   = 1'b1;
                    w_cnt_nxt = 4'd1;
                    if (WAIT_STATES <= 2) begin
                        w_load_rd   = 1'b1;
                        w_state_nxt = S_RD_HOLD;
                    end else begin
                        w_state_nxt = S_RD_WAIT;
                    end
                end else if (w_we_rise) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = S_WR_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (!Mem_OE) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_nxt = w_we_rise;
                    if (r_cnt == LP_RD_LAST) begin
                        w_load_rd   = 1'b1;
                        w_state_nxt = S_RD_HOLD;
                    end else begin
                        w_state_nxt = S_RD_WAIT;
                    end
                end
            end
            S_RD_HOLD: begin
                if (!Mem_OE) begin
                    w_clr_valid = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_nxt = w_we_rise;
                end
            end
            S_WR_WAIT: begin
                if (!Mem_WE) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_nxt = w_oe_rise;
                    if (r_cnt == LP_WR_LAST) begin
                        w_state_nxt = S_WR_HOLD;
                        if (w_prot_hit) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_mem_we      = 1'b1;
                            w_wr_done_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_WR_WAIT;
                    end
                end
            end
            S_WR_HOLD: begin
                if (!Mem_WE) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_nxt = w_oe_rise;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // FSM state, latched access operands and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_oe_d     <= 1'b0;
            r_we_d     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_oe_d    <= Mem_OE;
            r_we_d    <= Mem_WE;
            if (w_latch) begin
                r_addr  <= ADDR;
                r_wdata <= Data_from_CPU;
            end
            if (w_load_rd) begin
                r_rdata    <= r_mem[w_rd_addr];
                r_rd_valid <= 1'b1;
            end else if (w_clr_valid) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // RAM write port: contents survive reset by design
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign Data_to_CPU = r_rdata;
    assign Rd_Valid    = r_rd_valid;
    assign Wr_Done     = r_wr_done;
    assign Busy        = r_busy;
    assign Err         = r_err;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed self-checking bench for mem_wait_responder with WAIT_STATES=3.
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
module tb_mem_wait_responder;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Mem_OE = 1'b0;
    logic          Mem_WE = 1'b0;
    logic [AW-1:0] ADDR = '0;
    logic [DW-1:0] Data_from_CPU = '0;
    logic [DW-1:0] Data_to_CPU;
    logic          Rd_Valid;
    logic          Wr_Done;
    logic          Busy;
    logic          Err;

    int checks = 0;
    int failures = 0;

    mem_wait_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(3), .PROT_TOP(16)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Rd_Valid(Rd_Valid),
        .Wr_Done(Wr_Done), .Busy(Busy), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Three-cycle write strobe followed by one low cycle
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        Mem_WE = 1'b1; ADDR = a; Data_from_CPU = d;
        step(); step(); step();
        Mem_WE = 1'b0;
        step();
    endtask

    // Three-cycle read strobe followed by one low cycle; data/valid captured in cycle 3
    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
        Mem_OE = 1'b1; ADDR = a;
        step(); step();
        d = Data_to_CPU; v = Rd_Valid;
        step();
        Mem_OE = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", Data_to_CPU); end
        checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%b exp=0", Rd_Valid); end
        checks++; if (Wr_Done !== 1'b0) begin failures++; $display("FAIL rst_wr_done got=%b exp=0", Wr_Done); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", Busy); end
        checks++; if (Err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", Err); end
        Reset = 1'b1;
        step();
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_rel_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_read();
        write_word(10'h020, 16'h1234);
        Mem_OE = 1'b1; ADDR = 10'h020;
        step();
        ADDR = 10'h3FF;
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL rd_busy_c2 got=%b exp=1", Busy); end
        checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL rd_valid_c2 got=%b exp=0", Rd_Valid); end
        step();
        checks++; if (Rd_Valid !== 1'b1) begin failures++; $display("FAIL rd_valid_c3 got=%b exp=1", Rd_Valid); end
        checks++; if (Data_to_CPU !== 16'h1234) begin failures++; $display("FAIL rd_data_c3 got=%h exp=1234", Data_to_CPU); end
        step();
        checks++; if (Rd_Valid !== 1'b1) begin failures++; $display("FAIL rd_hold_c4 got=%b exp=1", Rd_Valid); end
        Mem_OE = 1'b0;
        step();
        checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL rd_valid_end got=%b exp=0", Rd_Valid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rd_busy_end got=%b exp=0", Busy); end
    endtask

    task automatic test_reset_mid_read();
        Mem_OE = 1'b1; ADDR = 10'h020;
        step();
        Reset = 1'b0; Mem_OE = 1'b0;
        #1;
        checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL midrst_data got=%h exp=0000", Data_to_CPU); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
        checks++; if (Rd_Valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", Rd_Valid); end
        step();
        Reset = 1'b1;
        step(); step();
        checks++; if (Busy !== 1'b0 || Err !== 1'b0) begin failures++; $display("FAIL midrst_after busy=%b err=%b exp=0,0", Busy, Err); end
    endtask

    task automatic test_write();
        logic [DW-1:0] d;
        logic v;
        Mem_WE = 1'b1; ADDR = 10'h021; Data_from_CPU = 16'hBEEF;
        step();
        Data_from_CPU = 16'h0000; ADDR = 10'h000;
        checks++; if (Wr_Done !== 1'b0) begin failures++; $display("FAIL wr_done_c2 got=%b exp=0", Wr_Done); end
        step();
        checks++; if (Wr_Done !== 1'b0) begin failures++; $display("FAIL wr_done_c3 got=%b exp=0", Wr_Done); end
        step();
        checks++; if (Wr_Done !== 1'b1) begin failures++; $display("FAIL wr_done_c4 got=%b exp=1", Wr_Done); end
        Mem_WE = 1'b0;
        step();
        checks++; if (Wr_Done !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL wr_end done=%b busy=%b exp=0,0", Wr_Done, Busy); end
        read_word(10'h021, d, v);
        checks++; if (d !== 16'hBEEF || v !== 1'b1) begin failures++; $display("FAIL wr_readback got=%h/%b exp=beef/1", d, v); end
        read_word(10'h000, d, v);
        checks++; if (d === 16'h0000 && v === 1'b1) begin end else if (v !== 1'b1) begin failures++; $display("FAIL wr_addr0_valid got=%b exp=1", v); end
    endtask

    task automatic test_early_drop();
        logic [DW-1:0] d;
        logic v;
        write_word(10'h022, 16'h5A5A);
        Mem_WE = 1'b1; ADDR = 10'h022; Data_from_CPU = 16'h1111;
        step(); step();
        Mem_WE = 1'b0;
        step();
        checks++; if (Err !== 1'b1) begin failures++; $display("FAIL wdrop_err got=%b exp=1", Err); end
        checks++; if (Wr_Done !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL wdrop_done_busy got=%b,%b exp=0,0", Wr_Done, Busy); end
        step();
        checks++; if (Err !== 1'b0 || Wr_Done !== 1'b0) begin failures++; $display("FAIL wdrop_after err=%b done=%b exp=0,0", Err, Wr_Done); end
        read_word(10'h022, d, v);
        checks++; if (d !== 16'h5A5A) begin failures++; $display("FAIL wdrop_ram got=%h exp=5a5a", d); end
        Mem_OE = 1'b1; ADDR = 10'h022;
        step();
        Mem_OE = 1'b0;
        step();
        checks++; if (Err !== 1'b1 || Rd_Valid !== 1'b0) begin failures++; $display("FAIL rdrop err=%b valid=%b exp=1,0", Err, Rd_Valid); end
        step();
    endtask

    task automatic test_conflict();
        logic [DW-1:0] d;
        logic v;
        Mem_OE = 1'b1; Mem_WE = 1'b1; ADDR = 10'h021; Data_from_CPU = 16'h7777;
        step();
        checks++; if (Err !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL conf_c2 err=%b busy=%b exp=1,0", Err, Busy); end
        step();
        checks++; if (Err !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL conf_c3 err=%b busy=%b exp=0,0", Err, Busy); end
        Mem_WE = 1'b0;
        step(); step();
        checks++; if (Busy !== 1'b0 || Rd_Valid !== 1'b0) begin failures++; $display("FAIL conf_held busy=%b valid=%b exp=0,0", Busy, Rd_Valid); end
        Mem_OE = 1'b0;
        step();
        read_word(10'h021, d, v);
        checks++; if (d !== 16'hBEEF || v !== 1'b1) begin failures++; $display("FAIL conf_ram got=%h/%b exp=beef/1", d, v); end
    endtask

    task automatic test_opposite();
        logic [DW-1:0] d;
        logic v;
        Mem_OE = 1'b1; ADDR = 10'h020;
        step();
        Mem_WE = 1'b1; Data_from_CPU = 16'hFFFF;
        step();
        checks++; if (Err !== 1'b1) begin failures++; $display("FAIL opp_err got=%b exp=1", Err); end
        checks++; if (Rd_Valid !== 1'b1 || Data_to_CPU !== 16'h1234) begin failures++; $display("FAIL opp_read got=%b/%h exp=1/1234", Rd_Valid, Data_to_CPU); end
        step();
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        checks++; if (Err !== 1'b0 || Wr_Done !== 1'b0) begin failures++; $display("FAIL opp_c4 err=%b done=%b exp=0,0", Err, Wr_Done); end
        step();
        read_word(10'h020, d, v);
        checks++; if (d !== 16'h1234) begin failures++; $display("FAIL opp_ram got=%h exp=1234", d); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic v;
        write_word(10'h030, 16'h0F0F);
        read_word(10'h030, d, v);
        checks++; if (d !== 16'h0F0F || v !== 1'b1) begin failures++; $display("FAIL b2b_read got=%h/%b exp=0f0f/1", d, v); end
        write_word(10'h3FF, 16'hC3C3);
        read_word(10'h3FF, d, v);
        checks++; if (d !== 16'hC3C3 || v !== 1'b1) begin failures++; $display("FAIL b2b_top got=%h/%b exp=c3c3/1", d, v); end
    endtask

    task automatic test_protect();
        logic [DW-1:0] d;
        logic v;
        Mem_WE = 1'b1; ADDR = 10'h005; Data_from_CPU = 16'hAAAA;
        step(); step(); step();
`ifdef MEM_PROTECT_EN
        checks++; if (Err !== 1'b1 || Wr_Done !== 1'b0) begin failures++; $display("FAIL prot_low err=%b done=%b exp=1,0", Err, Wr_Done); end
`else
        checks++; if (Err !== 1'b0 || Wr_Done !== 1'b1) begin failures++; $display("FAIL prot_low err=%b done=%b exp=0,1", Err, Wr_Done); end
`endif
        Mem_WE = 1'b0;
        step();
        read_word(10'h005, d, v);
`ifdef MEM_PROTECT_EN
        checks++; if (d === 16'hAAAA) begin failures++; $display("FAIL prot_ram got=%h exp=not aaaa", d); end
`else
        checks++; if (d !== 16'hAAAA) begin failures++; $display("FAIL prot_ram got=%h exp=aaaa", d); end
`endif
        Mem_WE = 1'b1; ADDR = 10'h010; Data_from_CPU = 16'hAAAA;
        step(); step(); step();
        checks++; if (Wr_Done !== 1'b1 || Err !== 1'b0) begin failures++; $display("FAIL prot_edge done=%b err=%b exp=1,0", Wr_Done, Err); end
        Mem_WE = 1'b0;
        step();
        read_word(10'h010, d, v);
        checks++; if (d !== 16'hAAAA) begin failures++; $display("FAIL prot_edge_ram got=%h exp=aaaa", d); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_reset_mid_read();
        test_write();
        test_early_drop();
        test_conflict();
        test_opposite();
        test_back_to_back();
        test_protect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
